// File: rtl/valid_ready_pkg.sv
// valid_ready_pkg: dual-rail codes and stage state shared by serializer and deserializer
package valid_ready_pkg;
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b01;
  localparam logic [1:0] DR_ZERO    = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, RESYNC} sipo_state_e;
  function automatic logic dr_is_bit(input logic [1:0] code);
    return code == DR_ONE || code == DR_ZERO;
  endfunction
endpackage

// File: rtl/valid_ready_std_if.sv
// valid_ready_std_if: valid/ready stream bundle with producer and consumer views
interface valid_ready_std_if #(parameter int WIDTH = 1);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport out    (output valid, output data, input ready);
  modport in     (input valid, input data, output ready);
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_hold_reg.sv
// vr_hold_reg: single-entry valid/ready holding register
module vr_hold_reg #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  assign valid = valid_q;
  assign data  = data_q;
  // a load in the handshake cycle refills the slot so words stream without a bubble
  always_comb begin
    valid_d = load || (valid_q && !ready);
    data_d  = load ? load_data : data_q;
  end
  // slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/sipo_dual_rail.sv
// sipo_dual_rail: reassembles LSB-first dual-rail bit frames into words
module sipo_dual_rail
  import valid_ready_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  valid_ready_std_if.in  din,
  input  logic           last,
  valid_ready_std_if.out dout,
  output logic           code_err,
  output logic           frame_err
);
  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);
  sipo_state_e          state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATAWIDTH-1:0] shreg_q, shreg_d;
  logic                 code_err_q, code_err_d, frame_err_q, frame_err_d;
  logic                 load, acc, is_bit, is_ill, at_end;
  assign at_end    = state_q == SHIFT && count_q == LAST_IDX;
  assign din.ready = !(at_end && dout.valid && !dout.ready);
  assign acc       = din.valid && din.ready;
  assign is_bit    = acc && dr_is_bit(din.data);
  assign is_ill    = acc && din.data == DR_ILLEGAL;
  assign code_err  = code_err_q;
  assign frame_err = frame_err_q;
  // framing FSM: nulls are ignored everywhere, RESYNC swallows beats silently until last
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    code_err_d  = 1'b0;
    frame_err_d = 1'b0;
    load        = 1'b0;
    for (int i = 0; i < DATAWIDTH; i++)
      if (is_bit && count_q == CW'(i)) shreg_d[i] = din.data == DR_ONE;
    if (state_q == RESYNC) begin
      if ((is_bit || is_ill) && last) state_d = IDLE;
    end else if (is_ill) begin
      code_err_d = 1'b1;
      count_d    = '0;
      state_d    = last ? IDLE : RESYNC;
    end else if (is_bit) begin
      if (last) begin
        load        = at_end;
        frame_err_d = !at_end;
        count_d     = '0;
        state_d     = IDLE;
      end else if (at_end) begin
        frame_err_d = 1'b1;
        count_d     = '0;
        state_d     = RESYNC;
      end else begin
        count_d = count_q + 1'b1;
        state_d = SHIFT;
      end
    end
  end
  // state, counter, shifter and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      code_err_q  <= code_err_d;
      frame_err_q <= frame_err_d;
    end
  end
  vr_hold_reg #(.WIDTH(DATAWIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(shreg_d),
    .valid    (dout.valid),
    .ready    (dout.ready),
    .data     (dout.data)
  );
endmodule

// File: tb/tb_sipo_dual_rail.sv
// tb_sipo_dual_rail: directed and random checks against a bit-list frame model
module tb_sipo_dual_rail;
  import valid_ready_pkg::*;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic last = 1'b0;
  logic code_err, frame_err;
  int checks = 0;
  int errors = 0;
  valid_ready_std_if #(.WIDTH(2))  din_if ();
  valid_ready_std_if #(.WIDTH(DW)) dout_if ();
  sipo_dual_rail #(.DATAWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din_if),
    .last     (last),
    .dout     (dout_if),
    .code_err (code_err),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  logic          m_bits[$];
  logic [DW-1:0] got[$];
  logic          drop, hold_v, exp_ce, exp_fe;
  logic [DW-1:0] hold_d;
  int            ce_seen, fe_seen;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic model_clear();
    m_bits.delete();
    drop = 1'b0;
    hold_v = 1'b0;
    hold_d = '0;
    exp_ce = 1'b0;
    exp_fe = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    din_if.valid = 1'b0;
    din_if.data = DR_NULL;
    last = 1'b0;
    dout_if.ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    chk("rst_dout_valid", dout_if.valid, 0);
    chk("rst_dout_data", dout_if.data, 0);
    chk("rst_code_err", code_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_din_ready", din_if.ready, 1);
  endtask
  task automatic cyc(input logic v, input logic [1:0] c, input logic l, input logic r, output logic a);
    logic exp_rdy, take, ld;
    logic [DW-1:0] w;
    din_if.valid = v;
    din_if.data = c;
    last = l;
    dout_if.ready = r;
    #1;
    exp_rdy = !(!drop && m_bits.size() == DW - 1 && hold_v && !r);
    chk("din_ready", din_if.ready, exp_rdy);
    chk("dout_valid", dout_if.valid, hold_v);
    if (hold_v) chk("dout_data", dout_if.data, hold_d);
    a = v && exp_rdy;
    take = hold_v && r;
    @(posedge clk);
    exp_ce = 1'b0;
    exp_fe = 1'b0;
    ld = 1'b0;
    w = '0;
    if (a) begin
      if (drop) begin
        if (c != DR_NULL && l) drop = 1'b0;
      end else if (c == DR_ILLEGAL) begin
        exp_ce = 1'b1;
        m_bits.delete();
        drop = !l;
      end else if (c != DR_NULL) begin
        m_bits.push_back(c == DR_ONE);
        if (l) begin
          if (m_bits.size() == DW) begin
            ld = 1'b1;
            foreach (m_bits[k]) w[k] = m_bits[k];
          end else exp_fe = 1'b1;
          m_bits.delete();
        end else if (m_bits.size() == DW) begin
          exp_fe = 1'b1;
          m_bits.delete();
          drop = 1'b1;
        end
      end
    end
    if (take) begin
      got.push_back(hold_d);
      hold_v = 1'b0;
    end
    if (ld) begin
      hold_v = 1'b1;
      hold_d = w;
    end
    #2;
    chk("code_err", code_err, exp_ce);
    chk("frame_err", frame_err, exp_fe);
    ce_seen += int'(code_err);
    fe_seen += int'(frame_err);
  endtask
  task automatic send(input logic [1:0] c, input logic l, input logic r);
    logic a;
    int n;
    n = 0;
    do begin
      cyc(1'b1, c, l, r, a);
      n++;
    end while (!a && n < 50);
    chk("send_accept", a, 1);
  endtask
  task automatic send_word(input logic [DW-1:0] w, input logic r);
    for (int k = 0; k < DW; k++) send(w[k] ? DR_ONE : DR_ZERO, k == DW - 1, r);
  endtask
  task automatic idle(input int n, input logic r);
    logic a;
    repeat (n) cyc(1'b0, DR_NULL, 1'b0, r, a);
  endtask
  initial begin
    logic a;
    logic [1:0] c;
    logic l;
    int sel;
    din_if.valid = 1'b0;
    din_if.data = DR_NULL;
    dout_if.ready = 1'b0;
    ce_seen = 0;
    fe_seen = 0;
    model_clear();
    do_reset();
    send_word(8'hA5, 1'b1);
    chk("a5_valid", dout_if.valid, 1);
    chk("a5_data", dout_if.data, 8'hA5);
    idle(2, 1'b1);
    chk("a5_count", got.size(), 1);
    chk("a5_word", got[0], 8'hA5);
    chk("a5_errs", ce_seen + fe_seen, 0);
    got.delete();
    send_word(8'h3C, 1'b0);
    for (int k = 0; k < DW - 1; k++) send(k[0] ? DR_ZERO : DR_ONE, 1'b0, 1'b0);
    cyc(1'b1, DR_ONE, 1'b1, 1'b0, a);
    chk("bp_stall", din_if.ready, 0);
    send(DR_ONE, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("bp_count", got.size(), 2);
    chk("bp_first", got[0], 8'h3C);
    chk("bp_second", got[1], 8'hD5);
    got.delete();
    for (int k = 0; k < DW; k++) begin
      send(DR_NULL, 1'b0, 1'b1);
      send(DR_ONE, k == DW - 1, 1'b1);
      send(DR_NULL, 1'b1, 1'b1);
    end
    idle(2, 1'b1);
    chk("null_count", got.size(), 1);
    chk("null_word", got[0], 8'hFF);
    got.delete();
    ce_seen = 0;
    fe_seen = 0;
    for (int k = 0; k < 3; k++) send(DR_ONE, 1'b0, 1'b1);
    send(DR_ILLEGAL, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send(DR_ZERO, k == 3, 1'b1);
    idle(2, 1'b1);
    chk("ill_ce", ce_seen, 1);
    chk("ill_fe", fe_seen, 0);
    chk("ill_noword", got.size(), 0);
    send_word(8'h5A, 1'b1);
    idle(2, 1'b1);
    chk("ill_next", got.size() == 1 ? got[0] : 8'h00, 8'h5A);
    got.delete();
    ce_seen = 0;
    fe_seen = 0;
    for (int k = 0; k < 4; k++) send(DR_ONE, k == 3, 1'b1);
    idle(1, 1'b1);
    chk("short_fe", fe_seen, 1);
    for (int k = 0; k < DW + 1; k++) send(DR_ZERO, k == DW, 1'b1);
    idle(2, 1'b1);
    chk("long_fe", fe_seen, 2);
    chk("frame_noword", got.size(), 0);
    chk("frame_ce", ce_seen, 0);
    send_word(8'h77, 1'b0);
    for (int k = 0; k < 5; k++) send(DR_ONE, 1'b0, 1'b0);
    do_reset();
    chk("midrst_valid", dout_if.valid, 0);
    send_word(8'h96, 1'b1);
    idle(2, 1'b1);
    chk("midrst_count", got.size(), 1);
    chk("midrst_word", got.size() == 1 ? got[0] : 8'h00, 8'h96);
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      c = sel == 0 ? DR_NULL : sel == 1 ? DR_ILLEGAL : ($urandom_range(0, 1) != 0 ? DR_ONE : DR_ZERO);
      l = m_bits.size() == DW - 1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 3) != 0, c, l, $urandom_range(0, 3) != 0, a);
    end
    idle(3, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
